// File: rtl/clmul_div_8bit.sv
// clmul_div_8bit: sequential GF(2) polynomial long divider, 15-bit dividend by 8-bit divisor,
// one dividend bit retired per clock with a start/done handshake.
module clmul_div_8bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [14:0] a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [14:0] q,
   output logic [6:0]  r
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [14:0] a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [2:0]  d_q, d_d;
   logic [7:0]  w_q, w_d;
   logic [14:0] qs_q, qs_d;
   logic [3:0]  i_q, i_d;
   logic [14:0] q_q, q_d;
   logic [6:0]  r_q, r_d;
   logic        err_q, err_d;
   logic [7:0]  t;
   logic        hit;
   logic [2:0]  deg;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      w_d     = w_q;
      qs_d    = qs_q;
      i_d     = i_q;
      q_d     = q_q;
      r_d     = r_q;
      err_d   = err_q;
      deg     = 3'd0;
      for (int k = 0; k < 8; k++)
         if (b[k]) deg = k[2:0];
      // Bring down the next dividend bit; subtract the divisor when the leading term lines up
      t   = {w_q[6:0], a_q[i_q]};
      hit = t[d_q];
      if (state_q == S_IDLE && start) begin
         if (b == 8'd0) begin
            state_d = S_DONE;
            q_d     = '0;
            r_d     = '0;
            err_d   = 1'b1;
         end else begin
            state_d = S_RUN;
            a_d     = a;
            b_d     = b;
            d_d     = deg;
            w_d     = '0;
            qs_d    = '0;
            i_d     = 4'd14;
         end
      end else if (state_q == S_RUN) begin
         w_d  = hit ? t ^ b_q : t;
         qs_d = {qs_q[13:0], hit};
         i_d  = i_q - 4'd1;
         if (i_q == 4'd0) begin
            state_d = S_DONE;
            q_d     = qs_d;
            r_d     = w_d[6:0];
            err_d   = 1'b0;
         end
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         w_q     <= '0;
         qs_q    <= '0;
         i_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         w_q     <= w_d;
         qs_q    <= qs_d;
         i_q     <= i_d;
         q_q     <= q_d;
         r_q     <= r_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign q    = q_q;
   assign r    = r_q;
   assign err  = err_q;
endmodule

// File: tb/tb_clmul_div_8bit.sv
// tb_clmul_div_8bit: directed and round-trip checks of the carry-less divider,
// including latency, result holding, divide-by-zero, ignored start and mid-run reset.
module tb_clmul_div_8bit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [14:0] a = '0;
   logic [7:0]  b = '0;
   logic        busy, done, err;
   logic [14:0] q;
   logic [6:0]  r;
   int          tests = 0;
   int          fails = 0;
   logic [22:0] held = '0;

   clmul_div_8bit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .err(err), .q(q), .r(r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] clmul(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p = '0;
      for (int k = 0; k < 8; k++)
         if (y[k]) p ^= 15'(x) << k;
      return p;
   endfunction

   function automatic int degree(input logic [7:0] y);
      int dg = 0;
      for (int k = 0; k < 8; k++)
         if (y[k]) dg = k;
      return dg;
   endfunction

   // poke > 0 pulses a competing start that many cycles into the run
   task automatic do_op(input string tag, input logic [14:0] av, input logic [7:0] bv,
                        input logic [14:0] eq, input logic [6:0] er, input logic ee, input int poke);
      int n, nb;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 15'($urandom); b = 8'($urandom);
      n = 1; nb = 0;
      while (!done && n < 40) begin
         if (busy) nb++;
         chk({tag, " hold"}, 32'({q, r, err}), 32'(held));
         start = (n == poke);
         if (n == poke) begin a = 15'h1234; b = 8'h05; end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk({tag, " latency"}, n, (bv == 8'd0) ? 1 : 16);
      chk({tag, " busy_cycles"}, nb, (bv == 8'd0) ? 0 : 15);
      chk({tag, " q"}, 32'(q), 32'(eq));
      chk({tag, " r"}, 32'(r), 32'(er));
      chk({tag, " err"}, 32'(err), 32'(ee));
      held = {q, r, err};
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(done), 0);
      chk({tag, " post_hold"}, 32'({q, r, err}), 32'(held));
   endtask

   initial begin
      logic [7:0]  x, y, z;
      logic [14:0] av;
      int          nd;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset out", 32'({q, r, err}), 0);
      rst_n = 1'b1;
      do_op("t1", 15'h0005, 8'h03, 15'h0003, 7'h00, 1'b0, 0);
      do_op("t2", 15'h0100, 8'h1B, 15'h001C, 7'h04, 1'b0, 0);
      do_op("t3", 15'h4001, 8'h80, 15'h0080, 7'h01, 1'b0, 0);
      do_op("t4", 15'h7FFF, 8'h01, 15'h7FFF, 7'h00, 1'b0, 0);
      do_op("div0", 15'h2AAA, 8'h00, 15'h0000, 7'h00, 1'b1, 0);
      do_op("t5", 15'h0000, 8'hFF, 15'h0000, 7'h00, 1'b0, 0);
      for (int k = 0; k < 200; k++) begin
         x = 8'($urandom);
         y = 8'($urandom_range(1, 255));
         z = 8'($urandom) & 8'((1 << degree(y)) - 1);
         av = clmul(x, y) ^ 15'(z);
         do_op("rnd", av, y, 15'(x), z[6:0], 1'b0, 0);
      end
      do_op("ign_start", 15'h0100, 8'h1B, 15'h001C, 7'h04, 1'b0, 5);
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("ign_start extra_done", nd, 0);
      do_op("pre_rst", 15'h7FFF, 8'h01, 15'h7FFF, 7'h00, 1'b0, 0);
      @(negedge clk);
      a = 15'h0100; b = 8'h1B; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst busy", 32'(busy), 0);
      chk("rst out", 32'({q, r, err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      held = '0;
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("rst no_done", nd, 0);
      do_op("after_rst", 15'h0100, 8'h1B, 15'h001C, 7'h04, 1'b0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
